// File: rtl/iob_parking_sensor_pkg.sv
// Shared constants for the parking-sensor peripheral: register map, event
// entry layout and CTRL bit positions.
package iob_parking_sensor_pkg;

  localparam int ADDR_STATUS     = 0;
  localparam int ADDR_FREE_CNT   = 1;
  localparam int ADDR_EVT_POP    = 2;
  localparam int ADDR_FIFO_LEVEL = 3;
  localparam int ADDR_CTRL       = 4;
  localparam int ADDR_TS         = 5;

  // Event entry: [31] new state, [30:24] spot index, [23:0] timestamp
  localparam int ENTRY_W   = 32;
  localparam int STATE_BIT = 31;
  localparam int IDX_LSB   = 24;
  localparam int IDX_W     = STATE_BIT - IDX_LSB;
  localparam int TS_W      = 24;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/iob_parking_sensor_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only
// when a pop happens in the same cycle, clear overrides everything.
module iob_parking_sensor_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_W:0]  level,
  output logic [DATA_W-1:0] dout
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam int LVL_W = DEPTH_W + 1;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/iob_parking_sensor.sv
// Parking-spot sensor peripheral: synchronised and debounced occupancy inputs,
// free-spot count and a timestamped change-event FIFO behind an IOb responder.
module iob_parking_sensor
  import iob_parking_sensor_pkg::*;
#(
  parameter int N_SPOTS      = 32,
  parameter int DEB_CYCLES   = 16,
  parameter int FIFO_DEPTH_W = 4,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [3:0]         wstrb,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  input  logic [N_SPOTS-1:0] sensor_in
);
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [N_SPOTS-1:0]  sync1_q, sync2_q, occ_q, pend_q, pend_d, toggle, push_oh;
  logic                en_q, en_d, ovf_q, ovf_d, ready_q;
  logic [31:0]         ts_q, ts_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_en, wr_en, ctrl_wr, clr, pop, push;
  logic [IDX_W-1:0]    push_idx;
  logic [ENTRY_W-1:0]  entry, fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [FIFO_DEPTH_W:0] fifo_level;
  logic                unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:CTRL_CLR+1];

  assign rd_en   = valid && !(|wstrb);
  assign wr_en   = valid && (|wstrb);
  assign ctrl_wr = wr_en && wstrb[0] && (address == ADDR_W'(ADDR_CTRL));
  assign clr     = ctrl_wr && wdata[CTRL_CLR];
  assign en_d    = ctrl_wr ? wdata[CTRL_EN] : en_q;
  assign ts_d    = en_q ? ts_q + 32'd1 : ts_q;
  assign pop     = rd_en && (address == ADDR_W'(ADDR_EVT_POP));

  // Per-spot debounce: a change is accepted after DEB_CYCLES consecutive
  // differing synchronised samples while enabled.
  for (genvar g = 0; g < N_SPOTS; g++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff, tc;

    assign diff      = sync2_q[g] ^ occ_q[g];
    assign tc        = (cnt_q == CNT_W'(DEB_CYCLES - 1));
    assign toggle[g] = en_q && diff && tc;

    always_comb begin
      cnt_d = '0;
      if (en_q && diff && !tc) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
  end

  // Lowest-index pending spot is logged each cycle
  assign push_oh = pend_q & (~pend_q + N_SPOTS'(1));
  assign push    = (|pend_q) && !clr;
  assign pend_d  = (pend_q & ~push_oh) | toggle;
  assign ovf_d   = clr ? 1'b0 : (ovf_q | (push && fifo_full && !pop));

  always_comb begin
    push_idx = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      if (push_oh[i]) push_idx = IDX_W'(i);
    end
  end

  always_comb begin
    entry                   = '0;
    entry[STATE_BIT]        = |(occ_q & push_oh);
    entry[IDX_LSB +: IDX_W] = push_idx;
    entry[TS_W-1:0]         = ts_q[TS_W-1:0];
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (address)
        ADDR_W'(ADDR_STATUS):     rdata_d[N_SPOTS-1:0] = occ_q;
        ADDR_W'(ADDR_FREE_CNT):   rdata_d = DATA_W'(N_SPOTS - $countones(occ_q));
        ADDR_W'(ADDR_EVT_POP):    rdata_d = fifo_empty ? '0 : DATA_W'(fifo_dout);
        ADDR_W'(ADDR_FIFO_LEVEL): begin
          rdata_d[DATA_W-1]       = ovf_q;
          rdata_d[FIFO_DEPTH_W:0] = fifo_level;
        end
        ADDR_W'(ADDR_CTRL):       rdata_d[CTRL_EN] = en_q;
        ADDR_W'(ADDR_TS):         rdata_d = DATA_W'(ts_q);
        default:                  rdata_d = '0;
      endcase
    end
  end

  // sensor_in is asynchronous; two flops before anything looks at it
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ts_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
      occ_q   <= occ_q ^ toggle;
      pend_q  <= pend_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      ts_q    <= ts_d;
      rdata_q <= rdata_d;
      ready_q <= valid;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

  iob_parking_sensor_fifo #(
    .DATA_W  (ENTRY_W),
    .DEPTH_W (FIFO_DEPTH_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .clear (clr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .dout  (fifo_dout)
  );

endmodule

// File: tb/tb_iob_parking_sensor.sv
// Bench for iob_parking_sensor: directed scenarios plus randomized sensor and
// bus traffic checked against a cycle-level behavioural model.
module tb_iob_parking_sensor;
  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sensor_in = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iob_parking_sensor dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .address   (address),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata),
    .ready     (ready),
    .sensor_in (sensor_in)
  );

  // Behavioural model: streak-length debounce, queue FIFO, plain counters
  logic [31:0] m_occ = '0, m_pend = '0, m_ts = '0, exp_rdata = '0;
  logic        m_en = 1'b0, m_ovf = 1'b0;
  logic [31:0] m_fifo[$];
  logic [31:0] m_hist[$];
  int          m_start[32];
  int          cyc = 0;

  initial begin : model
    logic [31:0] syn, tog, ent, rd;
    int          pidx;
    bit          do_pop, wr_ctrl, do_clr;
    m_hist.push_back(32'h0);
    m_hist.push_back(32'h0);
    foreach (m_start[s]) m_start[s] = -1;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_occ = '0; m_pend = '0; m_en = 1'b0; m_ovf = 1'b0; m_ts = '0;
        m_fifo.delete();
        m_hist.delete(); m_hist.push_back(32'h0); m_hist.push_back(32'h0);
        foreach (m_start[s]) m_start[s] = -1;
        exp_rdata = '0;
      end else begin
        syn = m_hist.pop_front();
        m_hist.push_back(sensor_in);
        case (address)
          3'd0: rd = m_occ;
          3'd1: rd = 32'(32 - $countones(m_occ));
          3'd2: rd = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
          3'd3: rd = {m_ovf, 26'b0, 5'(m_fifo.size())};
          3'd4: rd = {31'b0, m_en};
          3'd5: rd = m_ts;
          default: rd = 32'h0;
        endcase
        exp_rdata = (valid && wstrb == 4'h0) ? rd : 32'h0;
        do_pop  = valid && wstrb == 4'h0 && address == 3'd2 && m_fifo.size() > 0;
        wr_ctrl = valid && wstrb[0] && address == 3'd4;
        do_clr  = wr_ctrl && wdata[1];
        if (do_pop) void'(m_fifo.pop_front());
        pidx = -1;
        for (int s = 0; s < 32; s++) if (pidx < 0 && m_pend[s]) pidx = s;
        if (pidx >= 0) begin
          ent = {m_occ[pidx], 7'(pidx), m_ts[23:0]};
          m_pend[pidx] = 1'b0;
          if (!do_clr) begin
            if (m_fifo.size() < 16) m_fifo.push_back(ent);
            else m_ovf = 1'b1;
          end
        end
        if (do_clr) begin
          m_fifo.delete();
          m_ovf = 1'b0;
        end
        tog = '0;
        for (int s = 0; s < 32; s++) begin
          if (m_en && syn[s] != m_occ[s]) begin
            if (m_start[s] < 0) m_start[s] = cyc;
            if (cyc - m_start[s] == DEB - 1) begin
              tog[s] = 1'b1;
              m_start[s] = -1;
            end
          end else begin
            m_start[s] = -1;
          end
        end
        m_occ  = m_occ ^ tog;
        m_pend = m_pend | tog;
        if (m_en) m_ts = m_ts + 32'd1;
        if (wr_ctrl) m_en = wdata[0];
      end
      cyc++;
    end
  end

  // One bus request; caller is always just after a rising edge
  task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] got, output logic got_rdy, output logic [31:0] exp_d);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'h0;
    got = rdata; got_rdy = ready; exp_d = exp_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp; logic rdy;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else n_pass++;
    n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
    rst = 1'b1;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (rdy !== 1'b1 || got !== 32'h0) $display("FAIL reset_status got=%h/%b exp=0/1", got, rdy); else n_pass++;
    bus(3'd1, 0, 4'h0, got, rdy, exp);
    n_total++; if (rdy !== 1'b1 || got !== 32'd32) $display("FAIL reset_free got=%0d/%b exp=32/1", got, rdy); else n_pass++;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (rdy !== 1'b1 || got !== 32'h0) $display("FAIL reset_level got=%h/%b exp=0/1", got, rdy); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready_drop got=%b exp=0", ready); else n_pass++;
  endtask

  task automatic test_single_spot();
    logic [31:0] got, exp; logic rdy;
    bus(3'd4, 32'h1, 4'h1, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL wr_rdata got=%h exp=0", got); else n_pass++;
    sensor_in[5] = 1'b1;
    repeat (17) @(posedge clk); #1;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL single_status_early got=%h exp=0", got); else n_pass++;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h20) $display("FAIL single_status got=%h exp=20", got); else n_pass++;
    bus(3'd1, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'd31) $display("FAIL single_free got=%0d exp=31", got); else n_pass++;
    bus(3'd2, 0, 4'h0, got, rdy, exp);
    n_total++; if (got[31] !== 1'b1 || got[30:24] !== 7'd5) $display("FAIL single_evt got=%h exp_state=1 exp_idx=5", got); else n_pass++;
    n_total++; if (got[23:0] !== 24'd18) $display("FAIL single_evt_ts got=%0d exp=18", got[23:0]); else n_pass++;
    n_total++; if (got !== exp) $display("FAIL single_evt_model got=%h exp=%h", got, exp); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] got, exp; logic rdy;
    sensor_in[3] = 1'b1;
    repeat (10) @(posedge clk); #1;
    sensor_in[3] = 1'b0;
    repeat (30) @(posedge clk); #1;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h20) $display("FAIL glitch_status got=%h exp=20", got); else n_pass++;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL glitch_level got=%h exp=0", got); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] got, exp, e0, e1; logic rdy;
    sensor_in[0] = 1'b1;
    sensor_in[7] = 1'b1;
    repeat (25) @(posedge clk); #1;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'd2) $display("FAIL simul_level got=%h exp=2", got); else n_pass++;
    bus(3'd2, 0, 4'h0, e0, rdy, exp);
    n_total++; if (e0 !== exp) $display("FAIL simul_evt0_model got=%h exp=%h", e0, exp); else n_pass++;
    bus(3'd2, 0, 4'h0, e1, rdy, exp);
    n_total++; if (e1 !== exp) $display("FAIL simul_evt1_model got=%h exp=%h", e1, exp); else n_pass++;
    n_total++; if (e0[31:24] !== 8'h80 || e1[31:24] !== 8'h87) $display("FAIL simul_order got=%h,%h exp_hi=80,87", e0[31:24], e1[31:24]); else n_pass++;
    n_total++; if (e1[23:0] !== e0[23:0] + 24'd1) $display("FAIL simul_ts got=%0d exp=%0d", e1[23:0], e0[23:0] + 24'd1); else n_pass++;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'hA1) $display("FAIL simul_status got=%h exp=a1", got); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] got, exp; logic rdy;
    sensor_in[24:8] = '1;
    repeat (40) @(posedge clk); #1;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h80000010) $display("FAIL ovf_level got=%h exp=80000010", got); else n_pass++;
    bus(3'd4, 32'h3, 4'h2, got, rdy, exp);
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h80000010) $display("FAIL ovf_strobe_ignored got=%h exp=80000010", got); else n_pass++;
    bus(3'd4, 32'h3, 4'h1, got, rdy, exp);
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL ovf_cleared got=%h exp=0", got); else n_pass++;
    bus(3'd4, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h1) $display("FAIL ovf_ctrl got=%h exp=1", got); else n_pass++;
  endtask

  task automatic test_empty_pop();
    logic [31:0] got, exp; logic rdy;
    bus(3'd2, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL empty_pop got=%h exp=0", got); else n_pass++;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL empty_level got=%h exp=0", got); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp; logic rdy;
    logic [2:0]  adr[5] = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd1};
    logic [3:0]  stb[5] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 5; i++) begin
      bus(adr[i], 32'hFFFF_FFFF, stb[i], got, rdy, exp);
      n_total++; if (rdy !== 1'b1 || got !== exp) $display("FAIL b2b_%0d got=%h/%b exp=%h/1", i, got, rdy, exp); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (ready !== 1'b0) $display("FAIL b2b_ready_drop got=%b exp=0", ready); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] got, exp, d; logic rdy; logic [2:0] a; logic [3:0] s;
    int hold;
    for (int it = 0; it < 80; it++) begin
      sensor_in = sensor_in ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) sensor_in = sensor_in ^ (32'h1 << $urandom_range(0, 31));
      hold = int'($urandom_range(2, 40));
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          a = 3'($urandom_range(0, 7));
          s = 4'h0;
          d = $urandom;
          if ($urandom_range(0, 7) == 0) begin
            s = 4'($urandom_range(1, 15));
            d[0] = ($urandom_range(0, 9) != 0);
            d[1] = ($urandom_range(0, 3) == 0);
          end
          bus(a, d, s, got, rdy, exp);
          n_total++; if (rdy !== 1'b1 || got !== exp) $display("FAIL rand_req addr=%0d strb=%h got=%h/%b exp=%h/1", a, s, got, rdy, exp); else n_pass++;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp; logic rdy;
    bus(3'd4, 32'h1, 4'h1, got, rdy, exp);
    repeat (40) @(posedge clk); #1;
    sensor_in[9] = ~sensor_in[9];
    repeat (8) @(posedge clk); #1;
    valid = 1'b1; address = 3'd0; wstrb = 4'h0; rst = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    n_total++; if (ready !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", ready); else n_pass++;
    rst = 1'b1;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL rstmid_status got=%h exp=0", got); else n_pass++;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL rstmid_level got=%h exp=0", got); else n_pass++;
    bus(3'd5, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL rstmid_ts got=%h exp=0", got); else n_pass++;
    bus(3'd4, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL rstmid_ctrl got=%h exp=0", got); else n_pass++;
    repeat (30) @(posedge clk); #1;
    bus(3'd3, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0 || got !== exp) $display("FAIL rstmid_no_event got=%h exp=0", got); else n_pass++;
    bus(3'd0, 0, 4'h0, got, rdy, exp);
    n_total++; if (got !== 32'h0) $display("FAIL rstmid_status_hold got=%h exp=0", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_spot();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_empty_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
